// File: rtl/mlvd_turnaround_ctrl_if.sv
// mlvd_turnaround_ctrl_if
//   Bundle between the link/protocol logic (master) and the direction and
//   turnaround controller (slave) for a bank of M-LVDS transceiver channels.
//
//   Handshake: a requester raises req[i] and holds it high for the whole
//   transmission.
//   grant[i] is the acknowledgement and remains one-hot while DE drives the
//   pair. Dropping req[i] ends the transmission.
//   A requester must not treat its data as sent before it has seen grant[i].
//
//   Signals
//     req      [1:0]        transmit request per requester
//     mask_a   [G_SIZE-1:0] channels requester 0 drives (sampled at grant)
//     mask_b   [G_SIZE-1:0] channels requester 1 drives (sampled at grant)
//     rx_hold               incoming frame in progress
//     grant    [1:0]        one-hot grant
//     DE       [G_SIZE-1:0] per-channel driver enable
//     REn                   shared receiver enable, active low
//     tx_dir                high in any non-receive state
//     timeout               one-cycle pulse on forced release
interface mlvd_turnaround_ctrl_if #(
  parameter int G_SIZE = 8
);
  logic [1:0]        req;
  logic [G_SIZE-1:0] mask_a;
  logic [G_SIZE-1:0] mask_b;
  logic              rx_hold;
  logic [1:0]        grant;
  logic [G_SIZE-1:0] DE;
  logic              REn;
  logic              tx_dir;
  logic              timeout;

  modport master (
    output req, mask_a, mask_b, rx_hold,
    input  grant, DE, REn, tx_dir, timeout
  );

  modport slave (
    input  req, mask_a, mask_b, rx_hold,
    output grant, DE, REn, tx_dir, timeout
  );
endinterface

// File: rtl/mlvd_turnaround_ctrl.sv
// mlvd_turnaround_ctrl
//   Direction and turnaround controller for a bank of bidirectional M-LVDS
//   channels. Two local requesters are arbitrated round-robin. Every
//   direction change passes through a guard window of G_GUARD cycles with
//   both the local drivers (DE) and the local receivers (REn=1) off.
//
//   Optional feature: define MLVD_TX_TIMEOUT_EN to bound a grant to
//   G_TX_MAX cycles. A requester released by force is locked out until its req
//   has been seen low.
//
//   Ports
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        mlvd_turnaround_ctrl_if.slave (req/masks/rx_hold in,
//                grant/DE/REn/tx_dir/timeout out, all outputs registered)
//     state_dbg  current FSM state (0 RX, 1 RX_OFF, 2 TX, 3 TX_OFF)
module mlvd_turnaround_ctrl #(
  parameter int G_SIZE   = 8,
  parameter int G_GUARD  = 4,
  parameter int G_TX_MAX = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mlvd_turnaround_ctrl_if.slave       bus,
  output logic [1:0]                  state_dbg
);

  generate
    if (G_GUARD < 1 || G_GUARD > 255 || G_TX_MAX < 1) begin : g_bad_param
      $error("mlvd_turnaround_ctrl: G_GUARD must be 1..255 and G_TX_MAX >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_RX     = 2'd0,
    S_RX_OFF = 2'd1,
    S_TX     = 2'd2,
    S_TX_OFF = 2'd3
  } state_t;

  // The counter is loaded with G_GUARD-1 so that a guard state lasts exactly
  // G_GUARD cycles, including the cycle in which it is entered.
  localparam logic [7:0] GUARD_LOAD = 8'(G_GUARD - 1);

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic [1:0]        grant_q, grant_n;
  logic [G_SIZE-1:0] de_q, de_n;
  logic              ren_q;
  logic              timeout_q;
  logic              last, last_n;   // last granted requester (lowest priority)
  logic [1:0]        lock;           // requesters barred after a forced release
  logic [1:0]        cand;
  logic              pick_idx;
  logic              other_idx;
  logic              force_off;
  logic              tx_end;

`ifdef MLVD_TX_TIMEOUT_EN
  localparam int TX_W = $clog2(G_TX_MAX + 1);
  logic [TX_W-1:0] tx_cnt;

  // tx_cnt equals the number of completed cycles in TX; the grant is dropped
  // at the edge that would start cycle G_TX_MAX+1.
  assign force_off = (state == S_TX) && (tx_cnt == TX_W'(G_TX_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt <= '0;
      lock   <= 2'b00;
    end else begin
      tx_cnt <= (state == S_TX) ? tx_cnt + 1'b1 : '0;
      for (int i = 0; i < 2; i++) begin
        if (force_off && grant_q[i]) lock[i] <= 1'b1;
        else if (!bus.req[i])        lock[i] <= 1'b0;
      end
    end
  end
`else
  assign force_off = 1'b0;
  assign lock      = 2'b00;
`endif

  assign cand      = bus.req & ~lock;
  // With both candidates present, the one not granted last wins.
  assign pick_idx  = (cand == 2'b11) ? ~last : cand[1];
  assign other_idx = ~last;
  assign tx_end    = ~|(bus.req & grant_q) | force_off;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant_n = grant_q;
    de_n    = de_q;
    last_n  = last;
    case (state)
      S_RX: begin
        if (|cand && !bus.rx_hold) begin
          state_n = S_RX_OFF;
          cnt_n   = GUARD_LOAD;
        end
      end
      S_RX_OFF: begin
        if (cnt == 8'd0) begin
          if (|cand) begin
            state_n = S_TX;
            grant_n = pick_idx ? 2'b10 : 2'b01;
            de_n    = pick_idx ? bus.mask_b : bus.mask_a;
            last_n  = pick_idx;
          end else begin
            // Everyone withdrew while the receivers were already off.
            state_n = S_TX_OFF;
            cnt_n   = GUARD_LOAD;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_TX: begin
        if (tx_end) begin
          state_n = S_TX_OFF;
          grant_n = 2'b00;
          de_n    = '0;
          cnt_n   = GUARD_LOAD;
        end
      end
      S_TX_OFF: begin
        if (cnt == 8'd0) begin
          if (cand[other_idx]) begin
            // Direct handover: the guard just served is the dead time.
            state_n = S_TX;
            grant_n = other_idx ? 2'b10 : 2'b01;
            de_n    = other_idx ? bus.mask_b : bus.mask_a;
            last_n  = other_idx;
          end else begin
            state_n = S_RX;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: state_n = S_RX;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RX;
      cnt       <= 8'd0;
      grant_q   <= 2'b00;
      de_q      <= '0;
      ren_q     <= 1'b0;
      timeout_q <= 1'b0;
      last      <= 1'b1;   // favours requester 0 after reset
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      grant_q   <= grant_n;
      de_q      <= de_n;
      ren_q     <= (state_n != S_RX);
      timeout_q <= force_off;
      last      <= last_n;
    end
  end

  // Receivers are off exactly when the controller is not in RX, so the same
  // register serves REn and tx_dir.
  assign bus.grant   = grant_q;
  assign bus.DE      = de_q;
  assign bus.REn     = ren_q;
  assign bus.tx_dir  = ren_q;
  assign bus.timeout = timeout_q;
  assign state_dbg   = state;

endmodule
